pid_ctrl_param: RTL

//  Parametrised successor to the fixed-width segway PID. Turns pitch error (ptch) and pitch rate (ptch_rt) into a saturated signed motor command PID_cntrl.

---
 rtl/pid_ctrl_param.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pid_ctrl_param.sv
// Parametrised pitch PID with registered saturated output, conditional-integration
// anti-windup and a saturating soft-start timer. Optional macro: PID_FASTSIM_EN (fast soft-start ramp).
module pid_ctrl_param #(
  parameter int PTCH_W   = 16,
  parameter int ERR_W    = 10,
  parameter int P_COEFF  = 9,
  parameter int I_W      = 18,
  parameter int I_SHIFT  = 6,
  parameter int D_SHIFT  = 6,
  parameter int OUT_W    = 12,
  parameter int SS_CNT_W = 27,
  parameter int SS_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic signed [PTCH_W-1:0] ptch_rt,
  input  logic                     pwr_up,
  input  logic                     rider_off,
  output logic signed [OUT_W-1:0]  PID_cntrl,
  output logic        [SS_W-1:0]   ss_tmr
);

  localparam int P_W   = ERR_W + $clog2(P_COEFF + 1) + 1;
  localparam int D_W   = PTCH_W + 1;
  localparam int MAX_W = (P_W > I_W) ? ((P_W > D_W) ? P_W : D_W) : ((I_W > D_W) ? I_W : D_W);
  localparam int SUM_W = MAX_W + 2;

  localparam int ERR_MAX = 2 ** (ERR_W - 1) - 1;
  localparam int ERR_MIN = -(2 ** (ERR_W - 1));
  localparam int OUT_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W - 1));
  localparam int I_MAX   = 2 ** (I_W - 1) - 1;
  localparam int I_MIN   = -(2 ** (I_W - 1));

  localparam logic signed [PTCH_W-1:0] ERR_MAX_P = PTCH_W'(ERR_MAX);
  localparam logic signed [PTCH_W-1:0] ERR_MIN_P = PTCH_W'(ERR_MIN);
  localparam logic signed [ERR_W-1:0]  ERR_MAX_E = ERR_W'(ERR_MAX);
  localparam logic signed [ERR_W-1:0]  ERR_MIN_E = ERR_W'(ERR_MIN);
  localparam logic signed [SUM_W-1:0]  OUT_MAX_S = SUM_W'(OUT_MAX);
  localparam logic signed [SUM_W-1:0]  OUT_MIN_S = SUM_W'(OUT_MIN);
  localparam logic signed [I_W:0]      I_MAX_X   = (I_W + 1)'(I_MAX);
  localparam logic signed [I_W:0]      I_MIN_X   = (I_W + 1)'(I_MIN);
  localparam logic signed [P_W-1:0]    P_K       = P_W'(P_COEFF);
  localparam logic [SS_CNT_W-1:0]      SS_MAX    = {SS_CNT_W{1'b1}};

`ifdef PID_FASTSIM_EN
  localparam logic [SS_CNT_W-1:0] SS_INC = SS_CNT_W'(256);
`else
  localparam logic [SS_CNT_W-1:0] SS_INC = SS_CNT_W'(1);
`endif

  logic signed [ERR_W-1:0]  err_s;
  logic signed [P_W-1:0]    p_term_s;
  logic signed [I_W-1:0]    i_term_s;
  logic signed [PTCH_W-1:0] d_shift_s;
  logic signed [D_W-1:0]    d_term_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [OUT_W-1:0]  sat_s;
  logic signed [I_W:0]      i_acc_s;
  logic signed [I_W-1:0]    i_sat_s;
  logic                     windup_s;

  logic signed [OUT_W-1:0]  pid_q, pid_d;
  logic signed [I_W-1:0]    integ_q, integ_d;
  logic [SS_CNT_W-1:0]      cnt_q, cnt_d;

  // Error clipping and the three PID terms, summed at full width
  always_comb begin
    if (ptch > ERR_MAX_P) begin
      err_s = ERR_MAX_E;
    end else if (ptch < ERR_MIN_P) begin
      err_s = ERR_MIN_E;
    end else begin
      err_s = ptch[ERR_W-1:0];
    end
    p_term_s  = P_W'(err_s) * P_K;
    i_term_s  = integ_q >>> I_SHIFT;
    d_shift_s = ptch_rt >>> D_SHIFT;
    d_term_s  = -(D_W'(d_shift_s));
    sum_s     = SUM_W'(p_term_s) + SUM_W'(i_term_s) + SUM_W'(d_term_s);
  end

  // Output saturation and anti-windup detection on this cycle's sum
  always_comb begin
    if (sum_s > OUT_MAX_S) begin
      sat_s = OUT_MAX_S[OUT_W-1:0];
    end else if (sum_s < OUT_MIN_S) begin
      sat_s = OUT_MIN_S[OUT_W-1:0];
    end else begin
      sat_s = sum_s[OUT_W-1:0];
    end
    windup_s = ((sum_s > OUT_MAX_S) && !err_s[ERR_W-1] && (err_s != '0)) ||
               ((sum_s < OUT_MIN_S) && err_s[ERR_W-1]);
  end

  // Integrator next state: rider_off clear beats a valid sample; sums saturate rather than wrap
  always_comb begin
    i_acc_s = (I_W + 1)'(integ_q) + (I_W + 1)'(err_s);
    if (i_acc_s > I_MAX_X) begin
      i_sat_s = I_MAX_X[I_W-1:0];
    end else if (i_acc_s < I_MIN_X) begin
      i_sat_s = I_MIN_X[I_W-1:0];
    end else begin
      i_sat_s = i_acc_s[I_W-1:0];
    end
    if (rider_off) begin
      integ_d = '0;
    end else if (vld && !windup_s) begin
      integ_d = i_sat_s;
    end else begin
      integ_d = integ_q;
    end
    pid_d = sat_s;
  end

  // Soft-start counter: cleared while power is down, sticks at all-ones once full
  always_comb begin
    if (!pwr_up) begin
      cnt_d = '0;
    end else if (cnt_q > (SS_MAX - SS_INC)) begin
      cnt_d = SS_MAX;
    end else begin
      cnt_d = cnt_q + SS_INC;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_q   <= '0;
      integ_q <= '0;
      cnt_q   <= '0;
    end else begin
      pid_q   <= pid_d;
      integ_q <= integ_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PID_cntrl = pid_q;
  assign ss_tmr    = cnt_q[SS_CNT_W-1 -: SS_W];

endmodule
